stick_renderer: RTL and testbench
=================================

STICK_RENDERER -- requirements
Module: stick_renderer

Interface
REQ-001 Parameters (name, default, meaning): NUM_STICKS, 8, stick count (1..16); STICK_W, 64, stick width px; STICK_GAP, 32, gap px (left margin = gap); BASE_Y, 570, first row below sticks; H_BITS, 9, height width; IDX_BITS, 4, index width.
REQ-002 Ports (name direction width meaning): pclk in 1 pixel clock; rst_n in 1 async active-low reset.
REQ-003 hcount in 11, vcount in 11, hblnk in 1, vblnk in 1, hsync in 1, vsync in 1: timing from vga_timing.
REQ-004 wr_valid in 1, wr_ready out 1, wr_idx in IDX_BITS, wr_height in H_BITS: height-update handshake.
REQ-005 hl_en in 1, hl_a in IDX_BITS, hl_b in IDX_BITS: highlight pair request (sampled at commit).
REQ-006 r, g, b out 4 each; hs out 1; vs out 1: registered VGA outputs.
REQ-007 commit out 1: one-pclk pulse when shadow copied to active; wr_err out 1: one-pclk pulse on out-of-range index.

Function
REQ-008 Stick i spans x in [GAP+i*(W+GAP), GAP+i*(W+GAP)+W) and y in [BASE_Y-active_h[i], BASE_Y); height 0 draws nothing.
REQ-009 Pipeline latency exactly 2 pclk: stage 1 registers column hit/index, stage 2 registers colour; hsync/vsync delayed 2 pclk to hs/vs.
REQ-010 Colour priority: blank (hblnk|vblnk, delayed) -> 12'h000; hl stick A -> 12'h0f0; hl stick B -> 12'h00f; other stick -> 12'hf00; background -> 12'haaa.
REQ-011 Shadow table: transfer when wr_valid & wr_ready; shadow_h[wr_idx] <= wr_height next cycle.
REQ-012 wr_idx >= NUM_STICKS: transfer accepted, no table change, wr_err pulses one cycle later.
REQ-013 Commit event = vblnk rising edge (registered compare); in that cycle active_h <= shadow_h for all sticks, hl state <= {hl_en,hl_a,hl_b}; commit pulses.
REQ-014 wr_ready low only during the commit cycle; a wr_valid held across it completes next cycle and is visible in the following frame.
REQ-015 Active table and highlight state never change outside commit (no tearing mid-frame).
REQ-016 hl_a == hl_b: stick shows colour A. Highlight index >= NUM_STICKS: no stick highlighted for that slot.
REQ-017 Comparisons unsigned, 11-bit; H_BITS value > BASE_Y clamps top to row 0.
REQ-018 Elaboration error if last stick right edge exceeds 1024 or NUM_STICKS > 2^IDX_BITS.

Reset
REQ-019 rst_n low asynchronously clears: shadow_h, active_h, hl state, pipeline regs, {r,g,b}=0, hs=0, vs=0, commit=0, wr_err=0, vblnk history=1 (no commit on first edge-free frame).
REQ-020 wr_ready = 0 while rst_n low; 1 from first pclk edge after release.
REQ-021 Reset mid-transfer discards it; no partial write.

Structure
REQ-022 Shared package stick_pkg: colour constants (COL_BLANK, COL_BG, COL_STICK, COL_HL_A, COL_HL_B), default geometry constants.
REQ-023 One sub-module stick_column_decode: combinational hcount -> {hit, idx} for stage 1; everything else in stick_renderer.

Verification
REQ-024 Reset, no writes, full frame -> all visible pixels 12'haaa, blank 12'h000, hs/vs = hsync/vsync delayed 2.
REQ-025 Write idx 0 height 100 mid-frame -> current frame unchanged; after commit pixel (32,470) = 12'hf00, (32,469) = 12'haaa, (96,500) = 12'haaa.
REQ-026 Heights all 270, hl_en=1, hl_a=2, hl_b=5, commit -> (224,400)=12'h0f0, (512,400)=12'h00f, (32,400)=12'hf00.
REQ-027 wr_valid held with wr_idx 3 across vblnk rise -> wr_ready low exactly 1 cycle, write lands next cycle, shows after following commit.
REQ-028 wr_idx 9, NUM_STICKS=8 -> wr_err one pulse, tables unchanged.
REQ-029 rst_n asserted mid-line with heights loaded -> outputs 0 immediately, tables 0, next frame all background.

Source files
------------

// File: rtl/stick_pkg.sv
// Shared colours and default geometry for the stick renderer.
// Included by the top and its column decoder.
package stick_pkg;

    localparam logic [11:0] COL_BLANK = 12'h000;
    localparam logic [11:0] COL_BG    = 12'haaa;
    localparam logic [11:0] COL_STICK = 12'hf00;
    localparam logic [11:0] COL_HL_A  = 12'h0f0;
    localparam logic [11:0] COL_HL_B  = 12'h00f;

    localparam int DEF_NUM_STICKS = 8;
    localparam int DEF_STICK_W    = 64;
    localparam int DEF_STICK_GAP  = 32;
    localparam int DEF_BASE_Y     = 570;
    localparam int DEF_H_BITS     = 9;
    localparam int DEF_IDX_BITS   = 4;
    localparam int SCREEN_W       = 1024;

    // Left x of stick i; the left margin equals the gap.
    function automatic int stick_left(input int i, input int w, input int gap);
        return gap + i * (w + gap);
    endfunction

endpackage

// File: rtl/stick_column_decode.sv
// Combinational hcount -> {hit, idx}: which stick column, if any, covers this x.
// Columns never overlap, so at most one in_col bit is set.
module stick_column_decode
    import stick_pkg::*;
#(
    parameter int NUM_STICKS = DEF_NUM_STICKS,
    parameter int STICK_W    = DEF_STICK_W,
    parameter int STICK_GAP  = DEF_STICK_GAP,
    parameter int IDX_BITS   = DEF_IDX_BITS
) (
    input  logic [10:0]         hcount,
    output logic                hit,
    output logic [IDX_BITS-1:0] idx
);

    logic [NUM_STICKS-1:0] in_col;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_STICKS; gi++) begin : g_col
            localparam logic [10:0] LEFT  = 11'(stick_left(gi, STICK_W, STICK_GAP));
            localparam logic [10:0] RIGHT = 11'(stick_left(gi, STICK_W, STICK_GAP) + STICK_W);
            assign in_col[gi] = (hcount >= LEFT) && (hcount < RIGHT);
        end
    endgenerate

    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = 0; i < NUM_STICKS; i++) begin
            if (in_col[i]) begin
                hit = 1'b1;
                idx = IDX_BITS'(i);
            end
        end
    end

endmodule

// File: rtl/stick_renderer.sv
// Draws NUM_STICKS vertical bars over a VGA raster with a 2-pclk pipeline.
// Heights go to a shadow table and are copied to the active table only on vblank rise.
module stick_renderer
    import stick_pkg::*;
#(
    parameter int NUM_STICKS = DEF_NUM_STICKS,
    parameter int STICK_W    = DEF_STICK_W,
    parameter int STICK_GAP  = DEF_STICK_GAP,
    parameter int BASE_Y     = DEF_BASE_Y,
    parameter int H_BITS     = DEF_H_BITS,
    parameter int IDX_BITS   = DEF_IDX_BITS
) (
    input  logic                pclk,
    input  logic                rst_n,
    input  logic [10:0]         hcount,
    input  logic [10:0]         vcount,
    input  logic                hblnk,
    input  logic                vblnk,
    input  logic                hsync,
    input  logic                vsync,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [IDX_BITS-1:0] wr_idx,
    input  logic [H_BITS-1:0]   wr_height,
    input  logic                hl_en,
    input  logic [IDX_BITS-1:0] hl_a,
    input  logic [IDX_BITS-1:0] hl_b,
    output logic [3:0]          r,
    output logic [3:0]          g,
    output logic [3:0]          b,
    output logic                hs,
    output logic                vs,
    output logic                commit,
    output logic                wr_err
);

    localparam int LAST_RIGHT = stick_left(NUM_STICKS - 1, STICK_W, STICK_GAP) + STICK_W;

    generate
        if (LAST_RIGHT > SCREEN_W) begin : g_err_geom
            $error("stick_renderer: last stick right edge exceeds screen width");
        end
        if (NUM_STICKS < 1 || NUM_STICKS > 16 || NUM_STICKS > (1 << IDX_BITS)) begin : g_err_count
            $error("stick_renderer: NUM_STICKS out of range for IDX_BITS");
        end
    endgenerate

    logic [H_BITS-1:0]   shadow_h_reg [NUM_STICKS];
    logic [H_BITS-1:0]   active_h_reg [NUM_STICKS];
    logic                hl_en_reg;
    logic [IDX_BITS-1:0] hl_a_reg;
    logic [IDX_BITS-1:0] hl_b_reg;
    logic                vblnk_prev_reg;
    logic                ready_reg;
    logic                commit_evt;
    logic                wr_fire;
    logic                idx_ok;
    logic [NUM_STICKS-1:0] shadow_we;

    assign commit_evt = vblnk & ~vblnk_prev_reg;
    // Holding off writes in the commit cycle keeps the shadow->active copy coherent.
    assign wr_ready   = ready_reg & ~commit_evt;
    assign wr_fire    = wr_valid & wr_ready;
    assign idx_ok     = (int'(wr_idx) < NUM_STICKS);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_STICKS; gi++) begin : g_we
            assign shadow_we[gi] = wr_fire && (wr_idx == IDX_BITS'(gi));
        end
    endgenerate

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_STICKS; i++) begin
                shadow_h_reg[i] <= '0;
                active_h_reg[i] <= '0;
            end
            hl_en_reg      <= 1'b0;
            hl_a_reg       <= '0;
            hl_b_reg       <= '0;
            vblnk_prev_reg <= 1'b1;
            ready_reg      <= 1'b0;
            commit         <= 1'b0;
            wr_err         <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_STICKS; i++) begin
                if (shadow_we[i]) shadow_h_reg[i] <= wr_height;
                if (commit_evt)   active_h_reg[i] <= shadow_h_reg[i];
            end
            if (commit_evt) begin
                hl_en_reg <= hl_en;
                hl_a_reg  <= hl_a;
                hl_b_reg  <= hl_b;
            end
            vblnk_prev_reg <= vblnk;
            ready_reg      <= 1'b1;
            commit         <= commit_evt;
            wr_err         <= wr_fire & ~idx_ok;
        end
    end

    // Stage 1: column decode plus delayed row/blank/sync.
    logic                col_hit;
    logic [IDX_BITS-1:0] col_idx;
    logic                s1_hit_reg;
    logic [IDX_BITS-1:0] s1_idx_reg;
    logic [10:0]         s1_vcount_reg;
    logic                s1_blank_reg;
    logic                s1_hs_reg;
    logic                s1_vs_reg;

    stick_column_decode #(
        .NUM_STICKS (NUM_STICKS),
        .STICK_W    (STICK_W),
        .STICK_GAP  (STICK_GAP),
        .IDX_BITS   (IDX_BITS)
    ) u_decode (
        .hcount (hcount),
        .hit    (col_hit),
        .idx    (col_idx)
    );

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            s1_hit_reg    <= 1'b0;
            s1_idx_reg    <= '0;
            s1_vcount_reg <= '0;
            s1_blank_reg  <= 1'b0;
            s1_hs_reg     <= 1'b0;
            s1_vs_reg     <= 1'b0;
        end else begin
            s1_hit_reg    <= col_hit;
            s1_idx_reg    <= col_idx;
            s1_vcount_reg <= vcount;
            s1_blank_reg  <= hblnk | vblnk;
            s1_hs_reg     <= hsync;
            s1_vs_reg     <= vsync;
        end
    end

    // Stage 2: row test against the selected stick's height, then colour priority.
    logic [H_BITS-1:0] sel_h;
    logic [10:0]       top_y;
    logic              row_hit;
    logic              stick_px;
    logic [11:0]       colour_next;
    logic [11:0]       rgb_reg;
    logic              hs_reg;
    logic              vs_reg;

    always_comb begin
        sel_h = '0;
        for (int i = 0; i < NUM_STICKS; i++) begin
            if (s1_idx_reg == IDX_BITS'(i)) sel_h = active_h_reg[i];
        end
    end

    // A height taller than BASE_Y clamps the top to row 0.
    assign top_y    = (11'(sel_h) > 11'(BASE_Y)) ? 11'd0 : 11'(BASE_Y) - 11'(sel_h);
    assign row_hit  = (sel_h != '0) && (s1_vcount_reg >= top_y) && (s1_vcount_reg < 11'(BASE_Y));
    assign stick_px = s1_hit_reg && row_hit;

    always_comb begin
        colour_next = COL_BG;
        if (s1_blank_reg)
            colour_next = COL_BLANK;
        else if (stick_px && hl_en_reg && (s1_idx_reg == hl_a_reg))
            colour_next = COL_HL_A;
        else if (stick_px && hl_en_reg && (s1_idx_reg == hl_b_reg))
            colour_next = COL_HL_B;
        else if (stick_px)
            colour_next = COL_STICK;
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_reg <= '0;
            hs_reg  <= 1'b0;
            vs_reg  <= 1'b0;
        end else begin
            rgb_reg <= colour_next;
            hs_reg  <= s1_hs_reg;
            vs_reg  <= s1_vs_reg;
        end
    end

    assign {r, g, b} = rgb_reg;
    assign hs        = hs_reg;
    assign vs        = vs_reg;

endmodule

// File: tb/tb_stick_renderer.sv
// Scoreboarded bench for stick_renderer: each driven pixel pushes its expected colour/sync,
// popped when the pipeline delivers it; handshake and pulse outputs checked each cycle.
module tb_stick_renderer;

    localparam int NS = 8;

    logic        pclk  = 1'b0;
    logic        rst_n = 1'b1;
    logic [10:0] hcount = '0;
    logic [10:0] vcount = '0;
    logic        hblnk = 1'b0;
    logic        vblnk = 1'b0;
    logic        hsync = 1'b0;
    logic        vsync = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [3:0]  wr_idx = '0;
    logic [8:0]  wr_height = '0;
    logic        hl_en = 1'b0;
    logic [3:0]  hl_a = '0;
    logic [3:0]  hl_b = '0;
    logic [3:0]  r, g, b;
    logic        hs, vs, commit, wr_err;

    stick_renderer dut (
        .pclk      (pclk),
        .rst_n     (rst_n),
        .hcount    (hcount),
        .vcount    (vcount),
        .hblnk     (hblnk),
        .vblnk     (vblnk),
        .hsync     (hsync),
        .vsync     (vsync),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_idx    (wr_idx),
        .wr_height (wr_height),
        .hl_en     (hl_en),
        .hl_a      (hl_a),
        .hl_b      (hl_b),
        .r         (r),
        .g         (g),
        .b         (b),
        .hs        (hs),
        .vs        (vs),
        .commit    (commit),
        .wr_err    (wr_err)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        bit          chk;
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    int   m_shadow [NS];
    int   m_active [NS];
    bit   m_hl_en;
    int   m_hl_a, m_hl_b;
    bit   m_vb_prev;
    bit   m_ready_ok;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] model_colour(input int x, input int y, input bit blank);
        if (blank) return 12'h000;
        for (int i = 0; i < NS; i++) begin
            int left = 32 + i * 96;
            if (x >= left && x < left + 64 && m_active[i] > 0 && y < 570 && y + m_active[i] >= 570) begin
                if (m_hl_en && m_hl_a == i) return 12'h0f0;
                if (m_hl_en && m_hl_b == i) return 12'h00f;
                return 12'hf00;
            end
        end
        return 12'haaa;
    endfunction

    // One pixel cycle; exp_override < 0 means take the model's colour.
    task automatic step(input int x, input int y, input bit hb, input bit vb, input int exp_override);
        logic  hsr, vsr;
        bit    cmt, rdy, err;
        exp_t  e;
        hsr = 1'($urandom_range(0, 1));
        vsr = 1'($urandom_range(0, 1));
        hcount = 11'(x);
        vcount = 11'(y);
        hblnk  = hb;
        vblnk  = vb;
        hsync  = hsr;
        vsync  = vsr;
        cmt = vb && !m_vb_prev;
        rdy = m_ready_ok && !cmt;
        err = 1'b0;
        #2;
        check_val("wr_ready", 32'(wr_ready), 32'(rdy));
        e.chk = 1'b1;
        e.rgb = (exp_override < 0) ? model_colour(x, y, hb | vb) : 12'(exp_override);
        e.hs  = hsr;
        e.vs  = vsr;
        sb_q.push_back(e);
        if (wr_valid && rdy) begin
            $display("txn write idx=%0d height=%0d", wr_idx, wr_height);
            if (wr_idx < NS) m_shadow[wr_idx] = int'(wr_height);
            else err = 1'b1;
        end
        if (cmt) begin
            $display("txn commit hl_en=%0d a=%0d b=%0d", hl_en, hl_a, hl_b);
            m_active = m_shadow;
            m_hl_en  = hl_en;
            m_hl_a   = int'(hl_a);
            m_hl_b   = int'(hl_b);
        end
        m_vb_prev = vb;
        @(posedge pclk);
        #1;
        m_ready_ok = 1'b1;
        check_val("commit", 32'(commit), 32'(cmt));
        check_val("wr_err", 32'(wr_err), 32'(err));
        if (sb_q.size() >= 2) begin
            e = sb_q.pop_front();
            if (e.chk) begin
                check_val("rgb", 32'({r, g, b}), 32'(e.rgb));
                check_val("hs", 32'(hs), 32'(e.hs));
                check_val("vs", 32'(vs), 32'(e.vs));
            end
        end
    endtask

    task automatic visible(input int x, input int y, input int exp_override);
        step(x, y, 1'b0, 1'b0, exp_override);
    endtask

    task automatic vblank_period(input int n);
        for (int k = 0; k < n; k++) step(k, 600, k[0], 1'b1, -1);
    endtask

    task automatic write_tx(input int idx, input int h);
        wr_valid  = 1'b1;
        wr_idx    = 4'(idx);
        wr_height = 9'(h);
        visible(5, 5, -1);
        wr_valid  = 1'b0;
    endtask

    // Stick column edges against rows around BASE_Y and typical tops.
    task automatic probe_scan();
        int dxs [4] = '{-1, 0, 63, 64};
        int ys  [7] = '{299, 300, 469, 470, 568, 569, 570};
        for (int i = 0; i < NS; i++)
            for (int d = 0; d < 4; d++)
                for (int k = 0; k < 7; k++)
                    visible(32 + i * 96 + dxs[d], ys[k], -1);
        step(32, 560, 1'b1, 1'b0, -1);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        check_val("rst_rgb", 32'({r, g, b}), 32'h0);
        check_val("rst_hs", 32'(hs), 32'h0);
        check_val("rst_vs", 32'(vs), 32'h0);
        check_val("rst_commit", 32'(commit), 32'h0);
        check_val("rst_wr_err", 32'(wr_err), 32'h0);
        check_val("rst_wr_ready", 32'(wr_ready), 32'h0);
        sb_q.delete();
        for (int i = 0; i < NS; i++) begin
            m_shadow[i] = 0;
            m_active[i] = 0;
        end
        m_hl_en = 1'b0;
        m_hl_a = 0;
        m_hl_b = 0;
        m_ready_ok = 1'b0;
        repeat (2) @(posedge pclk);
        wr_valid = 1'b0;
        #3 rst_n = 1'b1;
        @(posedge pclk);
        #1;
        m_vb_prev  = vblnk;
        m_ready_ok = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        apply_reset();

        // Idle frame: everything background, blanking black.
        vblank_period(3);
        probe_scan();
        vblank_period(3);
        probe_scan();

        // Mid-frame write must not tear the current frame.
        visible(32, 470, 12'haaa);
        write_tx(0, 100);
        visible(32, 470, 12'haaa);
        visible(32, 569, 12'haaa);
        vblank_period(4);
        visible(32, 470, 12'hf00);
        visible(32, 469, 12'haaa);
        visible(96, 500, 12'haaa);
        probe_scan();

        // All heights 270 with highlight pair 2/5.
        for (int i = 0; i < NS; i++) write_tx(i, 270);
        write_tx(7, 1);
        hl_en = 1'b1; hl_a = 4'd2; hl_b = 4'd5;
        vblank_period(3);
        hl_en = 1'b0; hl_a = 4'd0; hl_b = 4'd0;
        visible(224, 400, 12'h0f0);
        visible(512, 400, 12'h00f);
        visible(32, 400, 12'hf00);
        visible(704, 569, 12'hf00);
        visible(704, 568, 12'haaa);
        probe_scan();

        // Same index in both slots shows colour A; out-of-range slot highlights nothing.
        hl_en = 1'b1; hl_a = 4'd3; hl_b = 4'd3;
        vblank_period(3);
        visible(320, 400, 12'h0f0);
        probe_scan();
        hl_a = 4'd12; hl_b = 4'd1;
        vblank_period(3);
        visible(128, 400, 12'h00f);
        visible(320, 400, 12'hf00);
        probe_scan();

        // Write held across the vblank rise: stalls one cycle, lands after, shows one frame later.
        visible(10, 10, -1);
        wr_valid = 1'b1; wr_idx = 4'd3; wr_height = 9'd50;
        step(0, 600, 1'b1, 1'b1, -1);
        step(0, 600, 1'b1, 1'b1, -1);
        wr_valid = 1'b0;
        vblank_period(2);
        visible(320, 350, 12'hf00);
        probe_scan();
        vblank_period(3);
        visible(320, 350, 12'haaa);
        visible(320, 520, 12'hf00);
        probe_scan();

        // Out-of-range index: error pulse, no table change.
        write_tx(9, 200);
        visible(5, 5, -1);
        vblank_period(3);
        visible(320, 520, 12'hf00);
        probe_scan();

        // Reset mid-line with a transfer pending.
        visible(32, 400, -1);
        visible(40, 400, -1);
        #2;
        wr_valid = 1'b1; wr_idx = 4'd0; wr_height = 9'd200;
        apply_reset();
        vblank_period(3);
        visible(32, 400, 12'haaa);
        probe_scan();

        repeat (3) visible(5, 5, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
